// File: rtl/updown_seq_pkg.sv
// Shared constants and helpers for the up/down sequence counter and its encoder.
package updown_seq_pkg;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Out-of-range load values pin to the top of the count range.
    function automatic logic [31:0] clamp_load(input logic [31:0] data, input logic [31:0] max);
        return (data > max) ? max : data;
    endfunction

endpackage

// File: rtl/seq_encoder.sv
// State-to-sequence mapping. UPDOWN_SEQ_GRAY_EN selects reflected Gray code;
// otherwise the raw binary count passes straight through.
module seq_encoder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] seq
);

`ifdef UPDOWN_SEQ_GRAY_EN
    assign seq = count ^ (count >> 1);
`else
    assign seq = count;
`endif

endmodule

// File: rtl/updown_seq_counter.sv
// Parametrised load/up/down counter over 0..MAX with wrap or saturate at the limits.
// Sequence output encoding is chosen by UPDOWN_SEQ_GRAY_EN inside seq_encoder.
module updown_seq_counter
    import updown_seq_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX      = 15,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] seq,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             at_max;
    logic             at_zero;

    assign at_max   = (count == MAX_V);
    assign at_zero  = (count == '0);
    assign load_val = WIDTH'(clamp_load(32'(data), 32'(MAX)));

    assign tc = ce & ~load & (((up == DIR_UP) & at_max) | ((up == DIR_DOWN) & at_zero));

    // Limits are detected by explicit compare so a non-power-of-two MAX wraps correctly.
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = load_val;
        end else if (ce) begin
            if (up == DIR_UP) begin
                if (!at_max) begin
                    count_nxt = count + WIDTH'(1);
                end else if (SATURATE == MODE_WRAP) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_nxt = count - WIDTH'(1);
                end else if (SATURATE == MODE_WRAP) begin
                    count_nxt = MAX_V;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end

    seq_encoder #(
        .WIDTH (WIDTH)
    ) u_seq_encoder (
        .count (count),
        .seq   (seq)
    );

endmodule
